regfile_alu_sequencer: RTL
==========================

// Module: regfile_alu_sequencer
// PURPOSE
//   Command sequencer for the register-file/ALU datapath (regFileWithAlu). Accepts
//   commands over a valid/ready handshake and drives func, crIn, leftAddr, rightAddr,
//   destAddr, writeEn and selInput. Runs multi-step LOAD, EXEC and READ bursts with
//   auto-incrementing register addresses and an internal carry flag for multi-word
//   arithmetic. The datapath's dataIn and dataOut buses bypass this block; it
//   controls only their handshakes.
// PARAMETERS
//   FUNC_PASS  3'd0  ALU func code that passes leftOp unchanged to the result (used by LOAD)
// PORTS
//   clock      in   1   system clock, rising edge
//   reset      in   1   asynchronous, active-high reset
//   cmdValid   in   1   command word valid
//   cmdReady   out  1   sequencer idle and able to accept a command
//   cmdWord    in   22  [21:20] op, [19:17] func, [16] useCarry, [15:12] count,
//                       [11:8] dest, [7:4] left, [3:0] right
//   inValid    in   1   datapath dataIn holds a valid word (LOAD)
//   inReady    out  1   sequencer consumes the dataIn word this cycle
//   outValid   out  1   datapath dataOut (leftOp) is valid (READ)
//   outReady   in   1   consumer takes dataOut this cycle
//   crOut      in   1   carry out from the ALU
//   func       out  3   ALU function code
//   crIn       out  1   ALU carry in
//   leftAddr   out  4   left-operand register address
//   rightAddr  out  4   right-operand register address
//   destAddr   out  4   destination register address
//   writeEn    out  1   register-file write enable
//   selInput   out  1   1 = dataIn drives leftOp
//   carryFlag  out  1   stored carry from the last EXEC step
//   busy       out  1   high in any state other than IDLE
//   cmdErr     out  1   one-cycle pulse on acceptance of reserved op 2'b11
// BEHAVIOUR
// - States: IDLE, LOAD, EXEC, READ. After reset the state is IDLE and every output is 0,
//   except cmdReady, which is 1.
// - IDLE: cmdReady=1. On cmdValid&cmdReady the block latches func and useCarry, loads
//   the step counter with count (bursts run count+1 steps, 1..16) and loads the
//   dest, left and right pointers. Next state by op:
//   00->LOAD, 01->EXEC, 10->READ, 11->stay IDLE with cmdErr pulsed on the next cycle.
// - The pointers drive destAddr, leftAddr and rightAddr directly from registers. Each
//   completed step increments the pointers the op uses by 1, modulo 16 (15 wraps to 0).
// - LOAD: selInput=1, func=FUNC_PASS, inReady=1, writeEn=inValid.
//   - On each inValid cycle, dataIn is written to R[dest] and dest increments.
//   - inValid low stalls the burst with no write.
// - EXEC: selInput=0, writeEn=1 every cycle, so one step per cycle.
//   - The result is written to R[dest]; dest, left and right all increment.
//   - crIn is 0 on step 0 when useCarry=0. On step 0 with useCarry=1, and on every
//     later step, crIn = carryFlag.
//   - carryFlag<=crOut at each EXEC step. carryFlag keeps its value across other ops.
// - READ: writeEn=0, selInput=0, outValid=1.
//   - A step completes on outReady; left then increments.
//   - outReady low holds leftAddr and outValid steady.
// - Completion: the final step (counter==0 when the step completes) returns the state to
//   IDLE on the next edge. cmdReady rises on that cycle, so back-to-back commands see a
//   one-cycle gap.
// - Outside their active states, writeEn, inReady and outValid are 0. cmdWord is ignored
//   while busy.
// - A write and a read of the same register in one step return the old value on the read
//   port; the datapath writes at the clock edge.
// - Asserting reset mid-burst immediately forces IDLE, writeEn=0, carryFlag=0 and pointers
//   to 0. Register-file contents are not cleared, and a partial burst is not resumed.
// TESTING
// - Reset mid-EXEC (step 2 of 4):
//   - writeEn drops in the same cycle, before the next edge.
//   - After release: cmdReady=1, busy=0, carryFlag=0.
// - LOAD count=1, dest=15, with 0xDEADBEEF then 0x12345678 and a 2-cycle inValid gap
//   between them:
//   - R15=0xDEADBEEF, R0=0x12345678 (dest wraps).
//   - No write during the gap; returns to IDLE after the 2nd word.
// - 64-bit add:
//   - Setup: load R0=0xFFFFFFFF, R1=0x00000000, R2=0x00000001, R3=0x00000000.
//   - Command: EXEC with the ALU add code, useCarry=0, count=1, dest=4, left=0, right=2.
//   - Result: R4=0x00000000, R5=0x00000001, crIn=0 then 1, carryFlag=0 at the end.
// - READ count=2, left=4 with outReady low for 3 cycles on step 1:
//   - Exactly three outValid&outReady transfers occur, at leftAddr 4, 5, 6.
//   - leftAddr holds at 5 during the stall.
// - cmdWord op=11:
//   - cmdErr is high for exactly 1 cycle, with no state change and no writeEn.
//   - A following valid command is accepted normally.
// - EXEC count=0 with useCarry=1 after a carry-producing add: crIn=1 on the single step;
//   cmdValid held high during the burst is not accepted until cmdReady returns.

Source files
------------

// File: rtl/regfile_alu_sequencer.sv
// Command sequencer for the register-file/ALU datapath: runs LOAD, EXEC and READ bursts
// with auto-incrementing register pointers and a stored carry for multi-word arithmetic.
module regfile_alu_sequencer #(
  parameter logic [2:0] FUNC_PASS = 3'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmdValid,
  output logic        cmdReady,
  input  logic [21:0] cmdWord,
  input  logic        inValid,
  output logic        inReady,
  output logic        outValid,
  input  logic        outReady,
  input  logic        crOut,
  output logic [2:0]  func,
  output logic        crIn,
  output logic [3:0]  leftAddr,
  output logic [3:0]  rightAddr,
  output logic [3:0]  destAddr,
  output logic        writeEn,
  output logic        selInput,
  output logic        carryFlag,
  output logic        busy,
  output logic        cmdErr,
  output logic [1:0]  stateDbg
);

  // Handshakes: a transfer happens on any cycle where valid and ready are both high at
  // the rising edge; valid never waits on ready (cmd, dataIn and dataOut alike).
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, EXEC = 2'd2, READ = 2'd3} state_t;

  state_t      state, nextState;
  logic [2:0]  funcReg;
  logic        useCarry;
  logic [3:0]  stepCnt;
  logic [3:0]  destPtr, leftPtr, rightPtr;
  logic        carryReg;
  logic        firstStep;
  logic        cmdErrReg;
  logic        stepDone;
  logic        accept;
  logic [1:0]  op;

  assign op        = cmdWord[21:20];
  assign accept    = cmdValid & cmdReady;
  assign destAddr  = destPtr;
  assign leftAddr  = leftPtr;
  assign rightAddr = rightPtr;
  assign carryFlag = carryReg;
  assign cmdErr    = cmdErrReg;
  assign busy      = (state != IDLE);
  assign stateDbg  = state;

  always_comb begin
    nextState = state;
    cmdReady  = 1'b0;
    inReady   = 1'b0;
    outValid  = 1'b0;
    writeEn   = 1'b0;
    selInput  = 1'b0;
    crIn      = 1'b0;
    func      = funcReg;
    stepDone  = 1'b0;
    case (state)
      IDLE: begin
        cmdReady = 1'b1;
        if (cmdValid) begin
          case (op)
            2'b00:   nextState = LOAD;
            2'b01:   nextState = EXEC;
            2'b10:   nextState = READ;
            default: nextState = IDLE;
          endcase
        end
      end
      LOAD: begin
        selInput = 1'b1;
        func     = FUNC_PASS;
        inReady  = 1'b1;
        writeEn  = inValid;
        stepDone = inValid;
      end
      EXEC: begin
        writeEn  = 1'b1;
        stepDone = 1'b1;
        // The first step of a chain starts from zero carry unless the command chains on.
        crIn     = (firstStep && !useCarry) ? 1'b0 : carryReg;
      end
      READ: begin
        outValid = 1'b1;
        stepDone = outReady;
      end
      default: nextState = IDLE;
    endcase
    if (stepDone && (stepCnt == 4'd0)) nextState = IDLE;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      funcReg   <= 3'd0;
      useCarry  <= 1'b0;
      stepCnt   <= 4'd0;
      destPtr   <= 4'd0;
      leftPtr   <= 4'd0;
      rightPtr  <= 4'd0;
      carryReg  <= 1'b0;
      firstStep <= 1'b0;
      cmdErrReg <= 1'b0;
    end else begin
      state     <= nextState;
      cmdErrReg <= accept && (op == 2'b11);
      if (accept && (op != 2'b11)) begin
        funcReg   <= cmdWord[19:17];
        useCarry  <= cmdWord[16];
        stepCnt   <= cmdWord[15:12];
        destPtr   <= cmdWord[11:8];
        leftPtr   <= cmdWord[7:4];
        rightPtr  <= cmdWord[3:0];
        firstStep <= 1'b1;
      end else if (stepDone) begin
        if (stepCnt != 4'd0) stepCnt <= stepCnt - 4'd1;
        firstStep <= 1'b0;
        case (state)
          LOAD: destPtr <= destPtr + 4'd1;
          EXEC: begin
            destPtr  <= destPtr + 4'd1;
            leftPtr  <= leftPtr + 4'd1;
            rightPtr <= rightPtr + 4'd1;
            carryReg <= crOut;
          end
          READ: leftPtr <= leftPtr + 4'd1;
          default: ;
        endcase
      end
    end
  end

endmodule
